// File: rtl/add8_errmon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add8_errmon_pkg
// Description : Shared widths and FSM state encoding for the 8-bit approximate
//               adder error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package add8_errmon_pkg;

    localparam int ERR_W = 9;   // |error| range 0..511
    localparam int SQ_W  = 18;  // 511^2 fits in 18 bits

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/add8_err_calc.sv
`default_nettype none
// ============================================================================
// Module      : add8_err_calc
// Description : Combinational exact sum, signed error, magnitude and mismatch
//               for one adder sample. Squared error present only when
//               ADD8_ERR_MONITOR_MSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module add8_err_calc
    import add8_errmon_pkg::*;
(
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    input  logic [ERR_W-1:0] i_approx,
`ifdef ADD8_ERR_MONITOR_MSE_EN
    output logic [SQ_W-1:0]  o_sq,
`endif
    output logic [ERR_W-1:0] o_abs,
    output logic             o_mismatch
);

    logic [ERR_W-1:0]  w_exact;
    logic signed [9:0] w_err;

    assign w_exact    = {1'b0, i_a} + {1'b0, i_b};
    assign w_err      = signed'({1'b0, w_exact}) - signed'({1'b0, i_approx});
    // Two's-complement negate on the low 9 bits; -511 maps cleanly to 511.
    assign o_abs      = w_err[9] ? (~w_err[8:0] + 9'd1) : w_err[8:0];
    assign o_mismatch = (w_err != 10'sd0);

`ifdef ADD8_ERR_MONITOR_MSE_EN
    assign o_sq = o_abs * o_abs;
`endif

endmodule
`default_nettype wire

// File: rtl/add8_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : add8_err_monitor
// Description : Characterisation monitor for an 8-bit approximate adder:
//               error count, sum of |error| and worst-case error over a run.
//               Define ADD8_ERR_MONITOR_MSE_EN to add the sq_sum_o output.
// Revision    : 1.0 - initial release
// ============================================================================
module add8_err_monitor
    import add8_errmon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       n_samples_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [7:0]             a_i,
    input  logic [7:0]             b_i,
    input  logic [ERR_W-1:0]       approx_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_W-1:0]       err_cnt_o,
    output logic [CNT_W+ERR_W-1:0] abs_sum_o,
`ifdef ADD8_ERR_MONITOR_MSE_EN
    output logic [CNT_W+SQ_W-1:0]  sq_sum_o,
`endif
    output logic [ERR_W-1:0]       wce_o
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_remain;
    logic                   r_drain;
    logic                   w_start;
    logic                   w_accept;

    logic                   r_s1_vld;
    logic [ERR_W-1:0]       r_s1_abs;
    logic                   r_s1_mis;
    logic [ERR_W-1:0]       w_abs;
    logic                   w_mis;

    logic [CNT_W-1:0]       r_err_cnt;
    logic [CNT_W+ERR_W-1:0] r_abs_sum;
    logic [ERR_W-1:0]       r_wce;

`ifdef ADD8_ERR_MONITOR_MSE_EN
    logic [SQ_W-1:0]        w_sq;
    logic [SQ_W-1:0]        r_s1_sq;
    logic [CNT_W+SQ_W-1:0]  r_sq_sum;
`endif

    add8_err_calc u_calc (
        .i_a        (a_i),
        .i_b        (b_i),
        .i_approx   (approx_i),
`ifdef ADD8_ERR_MONITOR_MSE_EN
        .o_sq       (w_sq),
`endif
        .o_abs      (w_abs),
        .o_mismatch (w_mis)
    );

    assign w_start  = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept = in_valid_i && (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_nxt = (n_samples_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid_i && (r_remain == CNT_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run bookkeeping: remaining samples and the two-cycle drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remain <= '0;
            r_drain  <= 1'b0;
        end else begin
            if (w_start) begin
                r_remain <= n_samples_i;
            end else if (w_accept) begin
                r_remain <= r_remain - CNT_W'(1);
            end
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
        end
    end

    // Stage 1 captures the per-sample error; stage 2 folds it into the totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_abs  <= '0;
            r_s1_mis  <= 1'b0;
            r_err_cnt <= '0;
            r_abs_sum <= '0;
            r_wce     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_abs <= w_abs;
                r_s1_mis <= w_mis;
            end
            if (w_start) begin
                r_s1_vld  <= 1'b0;
                r_err_cnt <= '0;
                r_abs_sum <= '0;
                r_wce     <= '0;
            end else if (r_s1_vld) begin
                r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, r_s1_mis};
                r_abs_sum <= r_abs_sum + {{CNT_W{1'b0}}, r_s1_abs};
                if (r_s1_abs > r_wce) begin
                    r_wce <= r_s1_abs;
                end
            end
        end
    end

`ifdef ADD8_ERR_MONITOR_MSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sq  <= '0;
            r_sq_sum <= '0;
        end else begin
            if (w_accept) begin
                r_s1_sq <= w_sq;
            end
            if (w_start) begin
                r_sq_sum <= '0;
            end else if (r_s1_vld) begin
                r_sq_sum <= r_sq_sum + {{CNT_W{1'b0}}, r_s1_sq};
            end
        end
    end

    assign sq_sum_o = r_sq_sum;
`endif

    assign in_ready_o = (r_state == ST_RUN);
    assign busy_o     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o     = (r_state == ST_DONE);
    assign err_cnt_o  = r_err_cnt;
    assign abs_sum_o  = r_abs_sum;
    assign wce_o      = r_wce;

endmodule
`default_nettype wire

// File: tb/tb_add8_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_add8_err_monitor
// Description : Directed self-checking bench for add8_err_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add8_err_monitor;

    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [CNT_W-1:0]   n_samples_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [7:0]         a_i;
    logic [7:0]         b_i;
    logic [8:0]         approx_i;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   err_cnt_o;
    logic [CNT_W+8:0]   abs_sum_o;
    logic [8:0]         wce_o;
`ifdef ADD8_ERR_MONITOR_MSE_EN
    logic [CNT_W+17:0]  sq_sum_o;
`endif

    int errors = 0;
    int checks = 0;

    add8_err_monitor #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .n_samples_i (n_samples_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .approx_i    (approx_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_cnt_o   (err_cnt_o),
        .abs_sum_o   (abs_sum_o),
`ifdef ADD8_ERR_MONITOR_MSE_EN
        .sq_sum_o    (sq_sum_o),
`endif
        .wce_o       (wce_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start_i     = 1'b1;
        n_samples_i = CNT_W'(n);
        tick();
        start_i     = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int ap);
        in_valid_i = 1'b1;
        a_i        = 8'(a);
        b_i        = 8'(b);
        approx_i   = 9'(ap);
        check("ready_on_send", {63'd0, in_ready_o}, 64'd1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int ec, input int as, input int wc);
        check({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(ec));
        check({tag, "_abs_sum"}, 64'(abs_sum_o), 64'(as));
        check({tag, "_wce"},     64'(wce_o),     64'(wc));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", {63'd0, done_o}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; n_samples_i = '0;
        in_valid_i = 1'b0; a_i = '0; b_i = '0; approx_i = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", {63'd0, in_ready_o}, 64'd0);
        check("rst_busy",  {63'd0, busy_o},     64'd0);
        check("rst_done",  {63'd0, done_o},     64'd0);
        check_stats("rst", 0, 0, 0);

        // Four-sample run: errors -1, 0, 21, 2
        start_run(4);
        check("run_busy", {63'd0, busy_o}, 64'd1);
        send(0, 8, 9);
        send(10, 5, 15);
        send(255, 255, 489);
        send(1, 1, 0);
        check("drain1_done", {63'd0, done_o}, 64'd0);
        check("drain1_busy", {63'd0, busy_o}, 64'd1);
        check("drain1_ready", {63'd0, in_ready_o}, 64'd0);
        tick();
        check("drain2_done", {63'd0, done_o}, 64'd0);
        tick();
        check("run4_done", {63'd0, done_o}, 64'd1);
        check("run4_busy", {63'd0, busy_o}, 64'd0);
        check_stats("run4", 3, 24, 21);

        // Samples offered in DONE are dropped; stats held
        in_valid_i = 1'b1; a_i = 8'd0; b_i = 8'd0; approx_i = 9'd300;
        tick(); tick(); tick();
        in_valid_i = 1'b0;
        check("hold_done", {63'd0, done_o}, 64'd1);
        check_stats("hold", 3, 24, 21);

        // Zero-length run straight from DONE
        begin
            int rdy = 0;
            start_run(0);
            check("n0_done", {63'd0, done_o}, 64'd1);
            check_stats("n0", 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                if (in_ready_o) rdy++;
                tick();
            end
            check("n0_never_ready", 64'(rdy), 64'd0);
        end

        // 256 back-to-back worst-case samples
        begin
            int acc = 0;
            start_run(256);
            in_valid_i = 1'b1; a_i = 8'd0; b_i = 8'd0; approx_i = 9'd511;
            for (int i = 0; i < 256; i++) begin
                if (in_ready_o) acc++;
                tick();
            end
            in_valid_i = 1'b0;
            check("b2b_accepted", 64'(acc), 64'd256);
            tick(); tick();
            check("b2b_done", {63'd0, done_o}, 64'd1);
            check_stats("b2b", 256, 130816, 511);
`ifdef ADD8_ERR_MONITOR_MSE_EN
            check("b2b_sq_sum", 64'(sq_sum_o), 64'd66846976);
`endif
        end

        // start_i during RUN ignored, gaps between samples
        start_run(3);
        send(1, 0, 0);
        start_i = 1'b1; n_samples_i = CNT_W'(7);
        tick();
        start_i = 1'b0;
        send(0, 0, 3);
        tick(); tick();
        send(5, 5, 10);
        wait_done(10);
        check_stats("gap", 2, 4, 3);
`ifdef ADD8_ERR_MONITOR_MSE_EN
        check("gap_sq_sum", 64'(sq_sum_o), 64'd10);
`endif

        // Reset mid-run with a sample in flight
        start_run(10);
        send(0, 0, 1);
        send(0, 0, 2);
        send(0, 0, 4);
        check_stats("mid", 2, 3, 2);
        rst = 1'b1; in_valid_i = 1'b1; approx_i = 9'd8;
        tick();
        rst = 1'b0; in_valid_i = 1'b0;
        check("mrst_ready", {63'd0, in_ready_o}, 64'd0);
        check("mrst_busy",  {63'd0, busy_o},     64'd0);
        check("mrst_done",  {63'd0, done_o},     64'd0);
        check_stats("mrst", 0, 0, 0);
        tick(); tick();
        check_stats("mrst_late", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/add8_err_monitor.md
ADD8_ERR_MONITOR -- requirements
Module: add8_err_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of sample counter and error-count output.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port start_i  input  1  one-cycle pulse that starts a characterisation run.
REQ-005 Port n_samples_i  input  CNT_W  samples in the run, latched on accepted start_i.
REQ-006 Port in_valid_i  input  1  sample valid.
REQ-007 Port in_ready_o  output  1  sample accepted when in_valid_i && in_ready_o.
REQ-008 Port a_i, b_i  input  8 each  operands applied to the approximate adder under test.
REQ-009 Port approx_i  input  9  approximate adder output O[8:0] for a_i, b_i.
REQ-010 Port busy_o  output  1  run in progress.
REQ-011 Port done_o  output  1  statistics final and held.
REQ-012 Port err_cnt_o  output  CNT_W  samples with approx_i != a_i+b_i (EP numerator).
REQ-013 Port abs_sum_o  output  CNT_W+9  sum of |a_i+b_i-approx_i| (MAE numerator).
REQ-014 Port wce_o  output  9  maximum |error| seen in run.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; SHALL be the only states.
REQ-016 IDLE or DONE + start_i: latch n_samples_i, clear all statistics, go RUN; if n_samples_i==0 go DONE directly with zeroed statistics.
REQ-017 start_i in RUN or DRAIN SHALL be ignored.
REQ-018 in_ready_o SHALL be 1 only in RUN; samples offered in other states are dropped without effect.
REQ-019 Exact sum = 9-bit zero-extended a_i+b_i; error = 10-bit signed exact - approx_i; |error| 9 bits, range 0..511.
REQ-020 Stage 1 registers |error| and mismatch flag on acceptance; stage 2 updates accumulators next cycle; latency accepted sample -> statistics = 2 cycles.
REQ-021 Accumulator widths cover worst case (511 x (2^CNT_W-1)); no saturation, no wrap.
REQ-022 Remaining-sample counter decrements per accepted sample; on accepting last sample go DRAIN.
REQ-023 DRAIN lasts exactly 2 cycles, then DONE.
REQ-024 busy_o = (RUN or DRAIN); done_o = DONE; statistic outputs are registered and hold their values in DONE until the next accepted start_i.
REQ-025 Back-to-back samples every cycle SHALL be sustained (throughput 1/cycle).

Reset
REQ-026 rst SHALL force IDLE, in_ready_o=0, busy_o=0, done_o=0, all statistics and pipeline registers 0, from any state including mid-run; in-flight samples discarded.

Configuration
REQ-027 Macro ADD8_ERR_MONITOR_MSE_EN defined: add output sq_sum_o (CNT_W+18 bits) = sum of error^2, same pipeline timing, same reset/clear rules.
REQ-028 Macro undefined: sq_sum_o port and squaring logic absent; all other behaviour identical.

Structure
REQ-029 Package add8_errmon_pkg SHALL hold the FSM state enum, ERR_W=9, SQ_W=18.
REQ-030 One sub-module add8_err_calc (combinational exact sum, signed error, abs, mismatch, optional square); FSM and accumulators in top.

Verification
REQ-031 rst mid-RUN after 3 samples -> next cycle IDLE, all outputs 0, done_o=0.
REQ-032 start n=4, samples (0,8,approx 9),(10,5,15),(255,255,489),(1,1,0) -> err_cnt 3, abs_sum 24, wce 21, done_o 2 cycles after last acceptance.
REQ-033 start n=0 -> done_o=1 next cycle, all statistics 0, in_ready_o never 1.
REQ-034 n=256 consecutive valid samples each |error|=511 -> abs_sum 130816, wce 511, no stall cycles.
REQ-035 start_i pulsed during RUN, valid gaps inserted -> run unaffected, counts exact; MSE_EN build: errors {1,-3} -> sq_sum 10.
